vid_dma_fetch: RTL
==================

# vid_dma_fetch

Video DMA fetch controller. Sits directly downstream of the video address counter: it takes the current 21-bit word address `vid[21:1]`, issues single-word read requests to the memory arbiter, and buffers the returned 16-bit words in a small FIFO for the shifter. Each completed fetch produces a one-clock advance strobe back to the counter. The block also flushes its state at frame start.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO depth in 16-bit words. Must be a power of two, 2..16.

Ports:
- `clk32`  in  1  system clock; all logic is on the rising edge.
- `porb`  in  1  power-on reset, asynchronous, active-low.
- `vid`  in  21  current video word address from the address counter (bits 21:1).
- `fetch_en`  in  1  fetch window from display timing; high from line prefetch start to line end.
- `frame_start`  in  1  one-clock pulse at vertical blank start; triggers a flush.
- `vid_inc`  out  1  one-clock pulse that advances the address counter by one word.
- `mem_req`  out  1  read request to the arbiter.
- `mem_addr`  out  21  word address of the request.
- `mem_ack`  in  1  one-clock acknowledge; `mem_data` is valid in the same cycle.
- `mem_data`  in  16  read data.
- `sh_ld`  in  1  shifter pop strobe.
- `sh_data`  out  16  word popped by the shifter.
- `fifo_cnt`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `underrun`  out  1  sticky flag, set on a pop from an empty FIFO.
- `underrun_clr`  in  1  clears `underrun`.

## Operation
- The FSM has four states: IDLE, REQ, SETTLE, DROP.
- **IDLE → REQ** when all of the following hold: `fetch_en` = 1, `frame_start` = 0, and `fifo_cnt < DEPTH`.
  - On this transition, `mem_addr` <= `vid` and `mem_req` <= 1.
- **REQ:**
  - `mem_req` and `mem_addr` are held stable until `mem_ack`.
  - On `mem_ack`, the block pushes `mem_data`, clears `mem_req`, sets `vid_inc` <= 1, and moves to SETTLE.
- **SETTLE:** lasts exactly one cycle (`vid_inc` = 0 again), then goes to IDLE. This lets the counter update before the next address is sampled.
- **Flush:** `frame_start` in any state clears the FIFO (count and pointers go to 0).
  - If the FSM is in REQ, it moves to DROP with `mem_req` still held. On `mem_ack`, the data is discarded, no `vid_inc` is issued, and the FSM goes to IDLE.
  - In IDLE or SETTLE, the FSM goes to IDLE.
- `fetch_en` falling while in REQ does not abort the request; it completes normally.
- **Pop:** `sh_ld` with `fifo_cnt > 0` sets `sh_data` <= head word and decrements the count.
  - `sh_ld` with `fifo_cnt` = 0 leaves `sh_data` holding its last value and sets `underrun`.
- **Simultaneous push and pop:**
  - Non-empty FIFO: the count is unchanged.
  - Empty FIFO: there is no bypass. `underrun` is set and the pushed word is stored (count = 1).
- **Push/flush collision:** a push in the same cycle as `frame_start` is discarded; flush wins.
- **`underrun` set vs. clear:** if `underrun_clr` and an underrun event occur in the same cycle, set wins.
- **Full FIFO:** no request is issued while `fifo_cnt` = `DEPTH`, so a push can never find the FIFO full.
- Pointers wrap modulo `DEPTH`. `fifo_cnt` never exceeds `DEPTH`.

## Timing
- Reset values: state = IDLE, `mem_req` = 0, `mem_addr` = 0, `vid_inc` = 0, `sh_data` = 0, `fifo_cnt` = 0, `underrun` = 0.
- All outputs are registered.
- **Request timing:** decision at edge t gives `mem_req` high after t. With `mem_ack` sampled at edge t+k (k ≥ 1):
  - `vid_inc` is high for the cycle after t+k.
  - `fifo_cnt` increments at t+k.
  - The earliest next `mem_req` rises after edge t+k+2.
- **Throughput:** with `mem_ack` arriving on the first cycle of `mem_req`, one word is fetched every 3 clocks.
- **Pop latency:** `sh_data` is valid the cycle after the `sh_ld` edge.
- **Reset mid-request:** `mem_req` drops immediately, asynchronously. A late `mem_ack` after reset is ignored.

## Test plan
- **Reset and steady fetch:** reset, then `fetch_en` = 1, `vid` = 0x01000, arbiter acks on the 1st cycle.
  - Required: `mem_addr` = 0x01000, one `vid_inc` per ack, and `mem_req` rises exactly 3 clocks apart.
  - Fill: the FIFO fills to 4 with no pops, then `mem_req` stays low.
- **Full then pop:** FIFO holds A1, A2, A3, A4; pulse `sh_ld` once.
  - Required: `sh_data` = A1, `fifo_cnt` = 3, and a new request issues 1 clock later.
- **Underrun:** `sh_ld` with an empty FIFO.
  - Required: `underrun` = 1 and `sh_data` unchanged. `underrun_clr` clears it, unless an underrun event occurs in the same cycle.
- **Flush mid-request:** `frame_start` while in REQ (2 words buffered), ack 3 clocks later.
  - Required: `fifo_cnt` = 0 immediately, no `vid_inc`, acked data not stored, FSM back in IDLE.
- **Simultaneous push and pop at count 2:** `mem_ack` and `sh_ld` in the same cycle.
  - Required: `fifo_cnt` stays 2 and the word order is preserved across pointer wrap (pushes 0..9 pop as 0..9).
- **Async reset mid-request:** `porb` low while in REQ.
  - Required: `mem_req` goes to 0 without a clock edge and all outputs take their reset values.

Source files
------------

// File: rtl/vid_dma_fetch.sv
// Video DMA fetch: one single-word read in flight, results buffered
// in a small FIFO for the shifter; frame start flushes everything.
module vid_dma_fetch #(
    parameter int DEPTH = 4
) (
    input  logic                     clk32,
    input  logic                     porb,
    input  logic [21:1]              vid,
    input  logic                     fetch_en,
    input  logic                     frame_start,
    output logic                     vid_inc,
    output logic                     mem_req,
    output logic [21:1]              mem_addr,
    input  logic                     mem_ack,
    input  logic [15:0]              mem_data,
    input  logic                     sh_ld,
    output logic [15:0]              sh_data,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     underrun,
    input  logic                     underrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, SETTLE, DROP} state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [21:1]     addr_q, addr_d;
    logic            inc_q, inc_d;
    logic [15:0]     shd_q, shd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic            und_q, und_d;
    logic [15:0]     mem_q [DEPTH];
    logic            push;
    logic            pop;
    logic            under_ev;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        inc_d   = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_en && !frame_start && (cnt_q < FULL)) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = vid;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    req_d = 1'b0;
                    // an ack colliding with a flush is discarded like a drop
                    if (frame_start) begin
                        state_d = IDLE;
                    end else begin
                        push    = 1'b1;
                        inc_d   = 1'b1;
                        state_d = SETTLE;
                    end
                end else if (frame_start) begin
                    state_d = DROP;
                end
            end
            SETTLE: state_d = IDLE;
            DROP: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop      = sh_ld && (cnt_q != '0);
    assign under_ev = sh_ld && (cnt_q == '0);

    always_comb begin
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        shd_d  = pop ? mem_q[rptr_q] : shd_q;
        und_d  = under_ev ? 1'b1 : (underrun_clr ? 1'b0 : und_q);
        if (frame_start) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            inc_q   <= 1'b0;
            shd_q   <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            inc_q   <= inc_d;
            shd_q   <= shd_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            und_q   <= und_d;
        end
    end

    always_ff @(posedge clk32) begin
        if (push) begin
            mem_q[wptr_q] <= mem_data;
        end
    end

    assign vid_inc  = inc_q;
    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign sh_data  = shd_q;
    assign fifo_cnt = cnt_q;
    assign underrun = und_q;

endmodule
